// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard detection from a per-register writeback
// scoreboard and a flag-write countdown.
// It drives the IF/ID hold and the ID/EX bubble, reports the stall cause and
// applies memory-freeze and flush.
// Optional feature macro: HAZ_PERF_CNT_EN adds per-cause stall-cycle counters.
module hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W   = 4,
    parameter int unsigned WB_DIST      = 2,
    parameter int unsigned LOAD_FWD_MAX = 1,
    parameter int unsigned FLAG_DIST    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_rt_store_data,
    input  logic                  id_br_reg,
    input  logic                  id_br_cond,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_is_load,
    input  logic                  id_sets_flags,
    input  logic                  mem_stall,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            stall_cause,
    output logic                  issue
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_lu,
    output logic [31:0]           perf_br,
    output logic [31:0]           perf_bf
`endif
);

    localparam int unsigned NREGS = 1 << REG_ADDR_W;
    localparam int unsigned CNT_W = (WB_DIST < 1) ? 1 : $clog2(WB_DIST + 1);
    localparam int unsigned FLG_W = (FLAG_DIST < 1) ? 1 : $clog2(FLAG_DIST + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WB_DIST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // A forwarding limit at or above WB_DIST means loads never stall EX consumers.
    localparam logic [CNT_W-1:0] FWD_LIM  = (LOAD_FWD_MAX >= WB_DIST) ? CNT_LOAD
                                                                       : CNT_W'(LOAD_FWD_MAX);
    localparam logic [FLG_W-1:0] FLG_LOAD = FLG_W'(FLAG_DIST);
    localparam logic [FLG_W-1:0] FLG_ONE  = FLG_W'(1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_LU   = 2'b01;
    localparam logic [1:0] CAUSE_BR   = 2'b10;
    localparam logic [1:0] CAUSE_BF   = 2'b11;

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [NREGS-1:0] ld_q;
    logic [NREGS-1:0] ld_d;
    logic [FLG_W-1:0] flag_cnt_q;
    logic [FLG_W-1:0] flag_cnt_d;

    logic haz_lu;
    logic haz_br;
    logic haz_bf;

    // Same-cycle hazard terms, stall/cause priority and issue.
    always_comb begin
        haz_lu      = 1'b0;
        haz_br      = 1'b0;
        haz_bf      = 1'b0;
        stall       = 1'b0;
        stall_cause = CAUSE_NONE;
        issue       = 1'b0;

        if (id_valid) begin
            // Register 0 is hardwired zero, so reads of it never hazard.
            if (id_rs_used && (id_rs != '0) && ld_q[id_rs] && (cnt_q[id_rs] > FWD_LIM))
                haz_lu = 1'b1;
            // Store data is consumed in MEM, late enough to forward from a load.
            if (id_rt_used && !id_rt_store_data && (id_rt != '0) && ld_q[id_rt]
                && (cnt_q[id_rt] > FWD_LIM))
                haz_lu = 1'b1;
            if (id_br_reg && (id_rs != '0) && (cnt_q[id_rs] != '0))
                haz_br = 1'b1;
            if (id_br_cond && (flag_cnt_q != '0))
                haz_bf = 1'b1;
        end

        stall = (haz_lu || haz_br || haz_bf) && !flush;

        if (stall) begin
            if (haz_br)      stall_cause = CAUSE_BR;
            else if (haz_lu) stall_cause = CAUSE_LU;
            else             stall_cause = CAUSE_BF;
        end

        issue = id_valid && !stall && !flush && !mem_stall;
    end

    // Scoreboard next state: countdown, then an issuing producer overrides.
    always_comb begin
        cnt_d      = cnt_q;
        ld_d       = ld_q;
        flag_cnt_d = flag_cnt_q;

        if (!mem_stall) begin
            for (int r = 0; r < NREGS; r++) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - CNT_ONE;
                    if (cnt_q[r] == CNT_ONE)
                        ld_d[r] = 1'b0;
                end
            end
            if (flag_cnt_q != '0)
                flag_cnt_d = flag_cnt_q - FLG_ONE;

            if (issue && id_wr_en && (id_rd != '0)) begin
                cnt_d[id_rd] = CNT_LOAD;
                ld_d[id_rd]  = id_is_load;
            end
            if (issue && id_sets_flags)
                flag_cnt_d = FLG_LOAD;
        end
    end

    // Scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                cnt_q[r] <= '0;
            ld_q       <= '0;
            flag_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                cnt_q[r] <= cnt_d[r];
            ld_q       <= ld_d;
            flag_cnt_q <= flag_cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_lu_q, perf_lu_d;
    logic [31:0] perf_br_q, perf_br_d;
    logic [31:0] perf_bf_q, perf_bf_d;

    // Count real stall cycles per cause; frozen cycles are not counted.
    always_comb begin
        perf_lu_d = perf_lu_q;
        perf_br_d = perf_br_q;
        perf_bf_d = perf_bf_q;
        if (stall && !mem_stall) begin
            case (stall_cause)
                CAUSE_LU: perf_lu_d = perf_lu_q + 32'd1;
                CAUSE_BR: perf_br_d = perf_br_q + 32'd1;
                CAUSE_BF: perf_bf_d = perf_bf_q + 32'd1;
                default:  ;
            endcase
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_q <= '0;
            perf_br_q <= '0;
            perf_bf_q <= '0;
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_br_q <= perf_br_d;
            perf_bf_q <= perf_bf_d;
        end
    end

    assign perf_lu = perf_lu_q;
    assign perf_br = perf_br_q;
    assign perf_bf = perf_bf_q;
`endif

endmodule
